ifu_rand_victim: RTL and testbench
==================================

# ifu_rand_victim

Random-replacement victim selector for the I-cache fill path under MBPTA operation. Sits directly downstream of the LFSR pseudo-random number generator: each I-cache miss samples the generator's output, resolves it against way-valid and way-lock state, and holds a one-hot victim way stable until the fill completes. Its output drives the way-enable of the I-cache tag/data write.

## Interface
- NUM_WAYS, 4: I-cache associativity; power of two, 2..8.
- WAY_BITS, $clog2(NUM_WAYS): width of the random index.

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- rand_i  in  WAY_BITS  random index from the PRNG; changes every cycle.
- miss_req_i  in  1  single-cycle pulse: miss needs a victim.
- way_valid_i  in  NUM_WAYS  valid bits of the missing set; stable during the miss_req_i cycle.
- way_lock_i  in  NUM_WAYS  locked ways; never chosen as victim.
- fill_done_i  in  1  fill write for the current victim completed.
- flush_i  in  1  abort the current miss.
- victim_valid_o  out  1  victim_way_o is valid.
- victim_way_o  out  NUM_WAYS  one-hot victim way; all zero when not valid.
- busy_o  out  1  miss in progress; new requests ignored.
- victim_err_o  out  1  one-cycle pulse: request rejected, every way locked.

## Operation
- FSM states: IDLE, HOLD. Reset state IDLE.
- IDLE, miss_req_i=1, flush_i=0: compute victim from the current-cycle inputs, register it, go to HOLD.
- Victim rule, in priority order:
  - any way with valid=0 and lock=0: lowest-index such way;
  - else way rand_i if unlocked;
  - else first unlocked way scanning upward from rand_i+1, modulo NUM_WAYS wrap-around;
  - all ways locked: no victim; stay IDLE; pulse victim_err_o.
- HOLD: victim_way_o held constant. Ignore rand_i, way_valid_i, way_lock_i, and miss_req_i.
- HOLD, fill_done_i=1 or flush_i=1: go to IDLE.
- fill_done_i in IDLE: ignored.
- flush_i in the same cycle as miss_req_i in IDLE: the request is dropped; no state change, no error.
- busy_o = (state==HOLD).
- Reset values: victim_valid_o=0, victim_way_o=0, busy_o=0, victim_err_o=0, state IDLE, stats counters 0.
- Reset asserted in HOLD: returns to IDLE next edge. The victim is discarded.

## Timing
- Request sampled at edge N.
- From cycle N+1: victim_valid_o=1, busy_o=1, victim_way_o valid.
- Release: fill_done_i or flush_i sampled at edge M. From cycle M+1: victim_valid_o=0, busy_o=0, victim_way_o=0.
  - Earliest next accepted request: cycle M+1.
  - Minimum miss-to-miss spacing: 2 cycles.
- victim_err_o: high for cycle N+1 only, for a rejected request sampled at edge N.
- Registered outputs only. No combinational path from any input to any output.

## Configuration
- Macro: RV_RAND_VICTIM_STATS_EN.
- Defined:
  - per-way 16-bit saturating counters, incremented at each victim registration; saturate at 0xFFFF;
  - counters exposed on output victim_cnt_o[NUM_WAYS*16-1:0], way 0 in bits [15:0];
  - input stats_clr_i zeroes all counters the next cycle;
  - stats_clr_i has priority over an increment in the same cycle.
  - These counters support the MBPTA uniformity check of the randomisation.
- Undefined: the counters, victim_cnt_o and stats_clr_i are absent. Behaviour is otherwise identical.

## Test plan
- Invalid-way priority:
  - Stimulus: NUM_WAYS=4, way_valid_i=4'b1011, lock=0, rand_i=0, miss_req_i pulse.
  - Response: victim_way_o=4'b0100 next cycle; busy_o=1.
  - Then fill_done_i: victim_valid_o=0 one cycle later.
- Random selection and lock wrap:
  - Stimulus: all valid, way_lock_i=4'b1000, rand_i=3.
  - Response: victim_way_o=4'b0001 (wrap).
  - Repeat with rand_i=1: victim_way_o=4'b0010.
- All locked:
  - Stimulus: way_lock_i=4'b1111, miss_req_i pulse.
  - Response: victim_err_o=1 for one cycle; victim_valid_o and busy_o stay 0.
- HOLD stability and ignored requests:
  - Stimulus: in HOLD, toggle rand_i every cycle and pulse miss_req_i.
  - Response: victim_way_o unchanged; no new victim.
  - Then flush_i: IDLE next cycle.
  - Then miss_req_i in that same cycle: accepted.
- Reset and simultaneous events:
  - rst asserted in HOLD: all outputs 0 next cycle.
  - miss_req_i with flush_i in IDLE: no victim, no error.
- Stats (macro defined):
  - 70000 misses with rand_i forced to 2, all valid, no locks: way-2 counter saturates at 0xFFFF; the others stay 0.
  - stats_clr_i with a concurrent victim registration: all counters 0 next cycle.

Source files
------------

// File: rtl/ifu_rand_victim.sv
// rtl/ifu_rand_victim.sv - I-cache random-replacement victim selector (optional stats: RV_RAND_VICTIM_STATS_EN)
module ifu_rand_victim #(
    parameter int NUM_WAYS = 4,
    parameter int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WAY_BITS-1:0]   rand_i,
    input  logic                  miss_req_i,
    input  logic [NUM_WAYS-1:0]   way_valid_i,
    input  logic [NUM_WAYS-1:0]   way_lock_i,
    input  logic                  fill_done_i,
    input  logic                  flush_i,
`ifdef RV_RAND_VICTIM_STATS_EN
    input  logic                  stats_clr_i,
    output logic [NUM_WAYS*16-1:0] victim_cnt_o,
`endif
    output logic                  victim_valid_o,
    output logic [NUM_WAYS-1:0]   victim_way_o,
    output logic                  busy_o,
    output logic                  victim_err_o
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state_q, state_d;
    logic [NUM_WAYS-1:0]   way_q, way_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic [NUM_WAYS-1:0]   pick;
    logic                  found;
    logic [WAY_BITS-1:0]   idx;
    logic                  any_unlocked;

    assign any_unlocked = ~&way_lock_i;

    // Invalid unlocked ways win outright; otherwise walk upward from rand_i with wrap.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!found && !way_valid_i[i] && !way_lock_i[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int k = 0; k < NUM_WAYS; k++) begin
            idx = rand_i + WAY_BITS'(k);
            if (!found && !way_lock_i[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_req_i && !flush_i) begin
                    if (any_unlocked) begin
                        state_d = HOLD;
                        way_d   = pick;
                        accept  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (fill_done_i || flush_i) begin
                    state_d = IDLE;
                    way_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                way_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            way_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            err_q   <= err_d;
        end
    end

    assign victim_valid_o = (state_q == HOLD);
    assign busy_o         = (state_q == HOLD);
    assign victim_way_o   = way_q;
    assign victim_err_o   = err_q;

`ifdef RV_RAND_VICTIM_STATS_EN
    logic [15:0] cnt_q [NUM_WAYS];

    // Clear beats a same-cycle increment so software sees a clean start.
    always_ff @(posedge clk) begin
        if (rst || stats_clr_i) begin
            for (int i = 0; i < NUM_WAYS; i++) cnt_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (pick[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        victim_cnt_o = '0;
        for (int i = 0; i < NUM_WAYS; i++) victim_cnt_o[i*16 +: 16] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_ifu_rand_victim.sv
// tb/tb_ifu_rand_victim.sv - self-checking bench for ifu_rand_victim
module tb_ifu_rand_victim;
    localparam int N  = 4;
    localparam int WB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [WB-1:0] rand_i;
    logic          miss_req_i;
    logic [N-1:0]  way_valid_i;
    logic [N-1:0]  way_lock_i;
    logic          fill_done_i;
    logic          flush_i;
    logic          victim_valid_o;
    logic [N-1:0]  victim_way_o;
    logic          busy_o;
    logic          victim_err_o;
`ifdef RV_RAND_VICTIM_STATS_EN
    logic              stats_clr_i;
    logic [N*16-1:0]   victim_cnt_o;
`endif

    always #5 clk = ~clk;

    ifu_rand_victim #(.NUM_WAYS(N), .WAY_BITS(WB)) dut (
        .clk(clk), .rst(rst), .rand_i(rand_i), .miss_req_i(miss_req_i),
        .way_valid_i(way_valid_i), .way_lock_i(way_lock_i),
        .fill_done_i(fill_done_i), .flush_i(flush_i),
`ifdef RV_RAND_VICTIM_STATS_EN
        .stats_clr_i(stats_clr_i), .victim_cnt_o(victim_cnt_o),
`endif
        .victim_valid_o(victim_valid_o), .victim_way_o(victim_way_o),
        .busy_o(busy_o), .victim_err_o(victim_err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic         m_busy = 1'b0;
    logic [N-1:0] m_way  = '0;
    logic         m_err  = 1'b0;
    int           m_cnt [N];

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  lock;
        logic [WB-1:0] rnd;
        logic [N-1:0]  exp_way;
        logic          exp_err;
    } vec_t;

    function automatic int ref_pick(logic [N-1:0] v, logic [N-1:0] l, logic [WB-1:0] r);
        for (int i = 0; i < N; i++)
            if (!v[i] && !l[i]) return i;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(r) + k) % N;
            if (!l[j]) return j;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one edge from the current inputs, clock the DUT, compare.
    task automatic tick(string name);
        int p;
        logic clr;
        logic acc;
        clr = 1'b0;
`ifdef RV_RAND_VICTIM_STATS_EN
        clr = stats_clr_i;
`endif
        acc = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_way = '0; m_err = 1'b0; clr = 1'b1;
        end else if (!m_busy) begin
            m_err = 1'b0;
            if (miss_req_i && !flush_i) begin
                p = ref_pick(way_valid_i, way_lock_i, rand_i);
                if (p < 0) m_err = 1'b1;
                else begin
                    m_busy = 1'b1; m_way = '0; m_way[p] = 1'b1; acc = 1'b1;
                end
            end
        end else begin
            m_err = 1'b0;
            if (fill_done_i || flush_i) begin
                m_busy = 1'b0; m_way = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (acc && m_way[i] && m_cnt[i] < 65535) m_cnt[i]++;
        end
        @(posedge clk);
        #1;
        check(name, {57'd0, victim_valid_o, busy_o, victim_err_o, victim_way_o},
                    {57'd0, m_busy, m_busy, m_err, m_way});
`ifdef RV_RAND_VICTIM_STATS_EN
        for (int i = 0; i < N; i++)
            check({name, "_cnt"}, 64'(victim_cnt_o[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{4'b1011, 4'b0000, 2'd0, 4'b0100, 1'b0};
        vecs[1] = '{4'b1111, 4'b1000, 2'd3, 4'b0001, 1'b0};
        vecs[2] = '{4'b1111, 4'b1000, 2'd1, 4'b0010, 1'b0};
        vecs[3] = '{4'b1111, 4'b1111, 2'd2, 4'b0000, 1'b1};
        vecs[4] = '{4'b0000, 4'b0001, 2'd3, 4'b0010, 1'b0};
        vecs[5] = '{4'b1110, 4'b0001, 2'd0, 4'b0010, 1'b0};
        vecs[6] = '{4'b1111, 4'b0110, 2'd1, 4'b1000, 1'b0};
        vecs[7] = '{4'b1111, 4'b0111, 2'd0, 4'b1000, 1'b0};
        vecs[8] = '{4'b1111, 4'b0000, 2'd2, 4'b0100, 1'b0};
        vecs[9] = '{4'b0111, 4'b0000, 2'd0, 4'b1000, 1'b0};
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        rst = 1'b1; rand_i = '0; miss_req_i = 1'b0; way_valid_i = '1; way_lock_i = '0;
        fill_done_i = 1'b0; flush_i = 1'b0;
`ifdef RV_RAND_VICTIM_STATS_EN
        stats_clr_i = 1'b0;
`endif
        tick("reset");
        check("reset_outs", {60'd0, victim_valid_o, busy_o, victim_err_o, |victim_way_o}, 64'd0);
        rst = 1'b0;
        tick("idle");

        for (int v = 0; v < 10; v++) begin
            way_valid_i = vecs[v].valid; way_lock_i = vecs[v].lock; rand_i = vecs[v].rnd;
            miss_req_i = 1'b1;
            tick("vec_req");
            miss_req_i = 1'b0;
            check($sformatf("vec%0d_way", v), 64'(victim_way_o), 64'(vecs[v].exp_way));
            check($sformatf("vec%0d_err", v), 64'(victim_err_o), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d_busy", v), 64'(busy_o), 64'(!vecs[v].exp_err));
            fill_done_i = 1'b1;
            tick("vec_release");
            fill_done_i = 1'b0;
            check($sformatf("vec%0d_rel", v), {60'd0, victim_valid_o, busy_o, victim_err_o, |victim_way_o}, 64'd0);
        end

        // HOLD stability against changing inputs and extra requests
        way_valid_i = '1; way_lock_i = '0; rand_i = 2'd2; miss_req_i = 1'b1;
        tick("hold_req");
        for (int c = 0; c < 6; c++) begin
            rand_i = WB'($urandom); way_valid_i = N'($urandom); way_lock_i = N'($urandom);
            miss_req_i = 1'b1;
            tick("hold_cycle");
            check("hold_way", 64'(victim_way_o), 64'(4'b0100));
        end
        miss_req_i = 1'b0; flush_i = 1'b1;
        tick("hold_flush");
        flush_i = 1'b0;
        check("flush_idle", 64'(busy_o), 64'd0);
        way_valid_i = '1; way_lock_i = '0; rand_i = 2'd1; miss_req_i = 1'b1;
        tick("after_flush_req");
        miss_req_i = 1'b0;
        check("after_flush_way", {59'd0, busy_o, victim_way_o}, {59'd0, 1'b1, 4'b0010});

        rst = 1'b1;
        tick("rst_in_hold");
        rst = 1'b0;
        check("rst_in_hold_outs", {60'd0, victim_valid_o, busy_o, victim_err_o, |victim_way_o}, 64'd0);

        miss_req_i = 1'b1; flush_i = 1'b1;
        tick("miss_flush");
        way_lock_i = '1;
        tick("miss_flush_locked");
        check("miss_flush_noerr", {62'd0, victim_valid_o, victim_err_o}, 64'd0);
        miss_req_i = 1'b0; flush_i = 1'b0; way_lock_i = '0;
        fill_done_i = 1'b1;
        tick("fill_in_idle");
        fill_done_i = 1'b0;

        for (int c = 0; c < 500; c++) begin
            rst         = ($urandom_range(0, 49) == 0);
            miss_req_i  = $urandom_range(0, 1) == 1;
            fill_done_i = ($urandom_range(0, 3) == 0);
            flush_i     = ($urandom_range(0, 7) == 0);
            rand_i      = WB'($urandom);
            way_valid_i = N'($urandom);
            way_lock_i  = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
`ifdef RV_RAND_VICTIM_STATS_EN
            stats_clr_i = ($urandom_range(0, 19) == 0);
`endif
            tick("random");
        end
        rst = 1'b0; miss_req_i = 1'b0; fill_done_i = 1'b1; flush_i = 1'b0;
        tick("random_drain");
        fill_done_i = 1'b0;

`ifdef RV_RAND_VICTIM_STATS_EN
        stats_clr_i = 1'b1;
        tick("stats_clr0");
        stats_clr_i = 1'b0;
        way_valid_i = '1; way_lock_i = '0; rand_i = 2'd2;
        for (int m = 0; m < 70000; m++) begin
            miss_req_i = 1'b1;
            tick("sat_req");
            miss_req_i = 1'b0; fill_done_i = 1'b1;
            tick("sat_fill");
            fill_done_i = 1'b0;
        end
        check("sat_way2", 64'(victim_cnt_o[47:32]), 64'h0000_0000_0000_FFFF);
        check("sat_others", {16'd0, victim_cnt_o[63:48], victim_cnt_o[31:0]}, 64'd0);
        miss_req_i = 1'b1; stats_clr_i = 1'b1;
        tick("clr_with_inc");
        miss_req_i = 1'b0; stats_clr_i = 1'b0;
        check("clr_with_inc_zero", victim_cnt_o, 64'd0);
        check("clr_with_inc_victim", 64'(victim_way_o), 64'(4'b0100));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
